// File: rtl/branch_resolver_if.sv
// Execute-to-fetch branch resolution bus: op intake from execute, record
// handshake to fetch, and the resolution statistics counters.
interface branch_resolver_if #(
  parameter int OPD_LENGTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
);
  logic                  in_valid;
  logic                  in_ready;
  logic [1:0]            br_kind;
  logic [3:0]            br_op;
  logic [OPD_LENGTH-1:0] comp_result;
  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] imm;
  logic [OPD_LENGTH-1:0] rs1;
  logic                  pred_taken;
  logic [ADDR_WIDTH-1:0] pred_target;
  logic                  out_valid;
  logic                  out_ready;
  logic                  taken;
  logic [ADDR_WIDTH-1:0] target;
  logic [ADDR_WIDTH-1:0] link_pc;
  logic                  mispredict;
  logic                  illegal;
  logic [CNT_WIDTH-1:0]  resolved_cnt;
  logic [CNT_WIDTH-1:0]  mispredict_cnt;

  modport master (
    output in_valid, br_kind, br_op, comp_result, pc, imm, rs1,
           pred_taken, pred_target, out_ready,
    input  in_ready, out_valid, taken, target, link_pc, mispredict,
           illegal, resolved_cnt, mispredict_cnt
  );

  modport slave (
    input  in_valid, br_kind, br_op, comp_result, pc, imm, rs1,
           pred_taken, pred_target, out_ready,
    output in_ready, out_valid, taken, target, link_pc, mispredict,
           illegal, resolved_cnt, mispredict_cnt
  );
endinterface

// File: rtl/branch_resolver.sv
// Resolves branch/JAL/JALR direction and target, checks the fetch prediction
// and hands a registered redirect record to fetch; squashes intake after a miss.
module branch_resolver #(
  parameter int OPD_LENGTH    = 32,
  parameter int ADDR_WIDTH    = 32,
  parameter int SQUASH_CYCLES = 2,
  parameter int CNT_WIDTH     = 16
) (
  input logic               clk,
  input logic               rst,
  branch_resolver_if.slave  bus
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] HOLD   = 2'd1;
  localparam logic [1:0] SQUASH = 2'd2;

  localparam int SQW = $clog2(SQUASH_CYCLES + 1);
  localparam logic [SQW-1:0]        SQ_LOAD  = SQW'(SQUASH_CYCLES);
  localparam logic [SQW-1:0]        SQ_ONE   = SQW'(1'b1);
  localparam logic [ADDR_WIDTH-1:0] FOUR     = ADDR_WIDTH'(3'd4);
  localparam logic [ADDR_WIDTH-1:0] LSB_MASK = {{(ADDR_WIDTH-1){1'b1}}, 1'b0};
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = CNT_WIDTH'(1'b1);
  localparam logic [CNT_WIDTH-1:0]  CNT_MAX  = {CNT_WIDTH{1'b1}};

  logic [1:0]            state_r;
  logic [SQW-1:0]        sq_cnt_r;
  logic                  out_valid_r;
  logic                  taken_r;
  logic [ADDR_WIDTH-1:0] target_r;
  logic [ADDR_WIDTH-1:0] link_pc_r;
  logic                  mispredict_r;
  logic                  illegal_r;
  logic [CNT_WIDTH-1:0]  resolved_cnt_r;
  logic [CNT_WIDTH-1:0]  mispredict_cnt_r;

  logic                  in_ready_s;
  logic                  accept_s;
  logic                  op_legal_s;
  logic                  taken_s;
  logic                  illegal_s;
  logic                  force_redirect_s;
  logic                  mispredict_s;
  logic [ADDR_WIDTH-1:0] link_s;
  logic [ADDR_WIDTH-1:0] rel_target_s;
  logic [ADDR_WIDTH-1:0] jalr_target_s;
  logic [ADDR_WIDTH-1:0] target_s;

  // Only bit 0 of the comparison result carries the condition.
  logic unused_bits;
  assign unused_bits = ^{bus.comp_result[OPD_LENGTH-1:1], bus.rs1};

  // Intake readiness depends on the live out_ready, so it stays combinational.
  always_comb begin
    in_ready_s = 1'b0;
    if (rst) begin
      in_ready_s = 1'b0;
    end else begin
      case (state_r)
        IDLE:    in_ready_s = 1'b1;
        HOLD:    in_ready_s = bus.out_ready & ~mispredict_r;
        SQUASH:  in_ready_s = 1'b0;
        default: in_ready_s = 1'b0;
      endcase
    end
  end

  assign accept_s = bus.in_valid & in_ready_s;

  // Legal comparison selects for conditional branches.
  always_comb begin
    op_legal_s = 1'b0;
    case (bus.br_op)
      4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0011, 4'b0111: op_legal_s = 1'b1;
      default: op_legal_s = 1'b0;
    endcase
  end

  // Direction, target and prediction check for the op presented this cycle.
  always_comb begin
    link_s           = bus.pc + FOUR;
    rel_target_s     = bus.pc + bus.imm;
    jalr_target_s    = (bus.rs1[ADDR_WIDTH-1:0] + bus.imm) & LSB_MASK;
    taken_s          = 1'b0;
    illegal_s        = 1'b0;
    force_redirect_s = 1'b0;
    target_s         = link_s;
    case (bus.br_kind)
      2'b00: begin
        taken_s   = op_legal_s & bus.comp_result[0];
        illegal_s = ~op_legal_s;
        if (taken_s) begin
          target_s = rel_target_s;
        end else begin
          target_s = link_s;
        end
      end
      2'b01: begin
        taken_s  = 1'b1;
        target_s = rel_target_s;
      end
      2'b10: begin
        taken_s  = 1'b1;
        target_s = jalr_target_s;
      end
      default: begin
        illegal_s        = 1'b1;
        force_redirect_s = 1'b1;
      end
    endcase
    mispredict_s = force_redirect_s | (taken_s != bus.pred_taken)
                 | (taken_s & (target_s != bus.pred_target));
  end

  // Handshake FSM and squash window.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      sq_cnt_r    <= '0;
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            state_r     <= HOLD;
            out_valid_r <= 1'b1;
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            if (mispredict_r) begin
              state_r     <= SQUASH;
              sq_cnt_r    <= SQ_LOAD;
              out_valid_r <= 1'b0;
            end else if (!bus.in_valid) begin
              state_r     <= IDLE;
              out_valid_r <= 1'b0;
            end
          end
        end
        SQUASH: begin
          sq_cnt_r <= sq_cnt_r - SQ_ONE;
          if (sq_cnt_r == SQ_ONE) begin
            state_r <= IDLE;
          end
        end
        default: begin
          state_r     <= IDLE;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  // Resolution record captured on every accepted op.
  always_ff @(posedge clk) begin
    if (rst) begin
      taken_r      <= 1'b0;
      target_r     <= '0;
      link_pc_r    <= '0;
      mispredict_r <= 1'b0;
      illegal_r    <= 1'b0;
    end else if (accept_s) begin
      taken_r      <= taken_s;
      target_r     <= target_s;
      link_pc_r    <= link_s;
      mispredict_r <= mispredict_s;
      illegal_r    <= illegal_s;
    end
  end

  // Saturating statistics counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      resolved_cnt_r   <= '0;
      mispredict_cnt_r <= '0;
    end else if (accept_s) begin
      if (resolved_cnt_r != CNT_MAX) begin
        resolved_cnt_r <= resolved_cnt_r + CNT_ONE;
      end
      if (mispredict_s && (mispredict_cnt_r != CNT_MAX)) begin
        mispredict_cnt_r <= mispredict_cnt_r + CNT_ONE;
      end
    end
  end

  assign bus.in_ready       = in_ready_s;
  assign bus.out_valid      = out_valid_r;
  assign bus.taken          = taken_r;
  assign bus.target         = target_r;
  assign bus.link_pc        = link_pc_r;
  assign bus.mispredict     = mispredict_r;
  assign bus.illegal        = illegal_r;
  assign bus.resolved_cnt   = resolved_cnt_r;
  assign bus.mispredict_cnt = mispredict_cnt_r;

endmodule
